// File: rtl/rep_umul_array_pkg.sv
// Shared types and sizing helpers for the windowed unary multiplier array.
package rep_umul_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_BITWIDTH = 8;

  function automatic int win_len(input int bw);
    return 1 << bw;
  endfunction

  // One extra bit so a full window of ones (bipolar) does not wrap
  function automatic int cnt_width(input int bw);
    return bw + 1;
  endfunction

  localparam int WIN_LEN = win_len(DEF_BITWIDTH);
  localparam int CNT_W   = cnt_width(DEF_BITWIDTH);

endpackage

// File: rtl/rep_umul_array_sobolrng.sv
// First-dimension Sobol generator: each step flips the direction-vector bit
// selected by the least-significant zero of the step index.
module sobolrng #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  output logic [BITWIDTH-1:0] sobolseq
);

  logic [BITWIDTH-1:0] idx;
  logic [BITWIDTH-1:0] lz;
  logic [BITWIDTH-1:0] vec;

  // one-hot of the lowest zero bit; all-ones index yields zero
  assign lz = ~idx & (idx + BITWIDTH'(1));

  for (genvar i = 0; i < BITWIDTH; i++) begin : g_vec
    assign vec[i] = lz[BITWIDTH-1-i];
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      idx      <= '0;
      sobolseq <= '0;
    end else if (iClr) begin
      idx      <= '0;
      sobolseq <= '0;
    end else if (iEn) begin
      idx      <= idx + BITWIDTH'(1);
      sobolseq <= sobolseq ^ vec;
    end
  end

endmodule

// File: rtl/rep_umul_array.sv
// Multi-lane windowed unary multiplier sharing one Sobol RNG.
// Optional bipolar (XNOR) mode enabled by defining REP_UMUL_BIPOLAR_EN.
module rep_umul_array
  import rep_umul_array_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int CHANNELS = 4
) (
  input  logic                                iClk,
  input  logic                                iRstN,
  input  logic [CHANNELS-1:0]                 iA,
  input  logic [CHANNELS*BITWIDTH-1:0]        iB,
  input  logic                                iLoadB,
  input  logic                                iStart,
  input  logic                                iEn,
`ifdef REP_UMUL_BIPOLAR_EN
  input  logic                                iBipolar,
`endif
  output logic [CHANNELS-1:0]                 oMult,
  output logic [CHANNELS*(BITWIDTH+1)-1:0]    oCnt,
  output logic                                oBusy,
  output logic                                oDone
);

  localparam int CW  = cnt_width(BITWIDTH);
  localparam int WIN = win_len(BITWIDTH);

  state_t                             state;
  logic [CW-1:0]                      cyc;
  logic [CHANNELS-1:0][BITWIDTH-1:0]  bbuf;
  logic [CHANNELS-1:0][CW-1:0]        cnt;
  logic [CHANNELS-1:0]                p;
  logic [BITWIDTH-1:0]                seq;
  logic                               start;
  logic                               adv;
`ifdef REP_UMUL_BIPOLAR_EN
  logic                               bip;
`endif

  assign start = (state != RUN) && iStart;
  assign adv   = (state == RUN) && iEn;
  assign oCnt  = cnt;

  sobolrng #(.BITWIDTH(BITWIDTH)) u_rng (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iEn      (adv),
    .iClr     (start),
    .sobolseq (seq)
  );

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic gt;
    assign gt = bbuf[k] > seq;
`ifdef REP_UMUL_BIPOLAR_EN
    assign p[k] = bip ? ~(iA[k] ^ gt) : (iA[k] & gt);
`else
    assign p[k] = iA[k] & gt;
`endif
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
      cyc   <= '0;
      bbuf  <= '0;
      cnt   <= '0;
      oMult <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
`ifdef REP_UMUL_BIPOLAR_EN
      bip   <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      // weights are frozen for the whole window
      if (state != RUN && iLoadB) bbuf <= iB;
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            state <= RUN;
            cyc   <= '0;
            cnt   <= '0;
            oMult <= '0;
            oBusy <= 1'b1;
`ifdef REP_UMUL_BIPOLAR_EN
            bip   <= iBipolar;
`endif
          end
        end
        RUN: begin
          if (iEn) begin
            cyc <= cyc + CW'(1);
            for (int k = 0; k < CHANNELS; k++) cnt[k] <= cnt[k] + CW'(p[k]);
            if (cyc == CW'(WIN - 1)) begin
              state <= DONE;
              oDone <= 1'b1;
              oBusy <= 1'b0;
              oMult <= '0;
            end else begin
              oMult <= p;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rep_umul_array.sv
// Randomized self-checking bench for rep_umul_array against a closed-form Sobol model.
module tb_rep_umul_array;

  localparam int BW  = 8;
  localparam int C   = 4;
  localparam int CW  = BW + 1;
  localparam int WIN = 1 << BW;

  logic              iClk = 1'b0;
  logic              iRstN;
  logic [C-1:0]      iA;
  logic [C*BW-1:0]   iB;
  logic              iLoadB, iStart, iEn;
`ifdef REP_UMUL_BIPOLAR_EN
  logic              iBipolar;
`endif
  logic [C-1:0]      oMult;
  logic [C*CW-1:0]   oCnt;
  logic              oBusy, oDone;

  int n_chk = 0;
  int n_fail = 0;
  int model_w [C];
  int got_cnt [C];
  int got_edges, got_stalls;

  always #5 iClk = ~iClk;

  rep_umul_array #(.BITWIDTH(BW), .CHANNELS(C)) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iA      (iA),
    .iB      (iB),
    .iLoadB  (iLoadB),
    .iStart  (iStart),
    .iEn     (iEn),
`ifdef REP_UMUL_BIPOLAR_EN
    .iBipolar(iBipolar),
`endif
    .oMult   (oMult),
    .oCnt    (oCnt),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  // n-th Sobol point (dimension 1, Gray-code order) = bit-reversed Gray code of n
  function automatic int sobol_ref(input int n);
    int g, r;
    g = n ^ (n >> 1);
    r = 0;
    for (int i = 0; i < BW; i++) if (g[i]) r |= 1 << (BW - 1 - i);
    return r;
  endfunction

  // Must be entered at a negedge; leaves at the negedge of the oDone cycle
  // (or one cycle later when post_idle is set).
  task automatic run_window(input logic [C*BW-1:0] b, input bit do_load,
                            input logic [C-1:0] aval, input bit arand,
                            input int stall_pct, input bit bip,
                            input bit load_mid, input bit post_idle, input string tag);
    int n, edges, stalls;
    int expc [C];
    logic [C-1:0] a, pk, prev;
    bit en, gt, pb;
    iB = b; iLoadB = do_load; iStart = 1'b1; iEn = 1'b0;
`ifdef REP_UMUL_BIPOLAR_EN
    iBipolar = bip;
`endif
    if (do_load) for (int k = 0; k < C; k++) model_w[k] = int'(b[k*BW +: BW]);
    @(posedge iClk); edges = 1; stalls = 0;
    @(negedge iClk);
    iLoadB = 1'b0; iStart = 1'b0;
    n_chk++;
    if (oBusy !== 1'b1 || oDone !== 1'b0 || oCnt !== '0 || oMult !== '0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b done=%b cnt=%h mult=%b, want busy=1 done=0 cnt=0 mult=0",
               tag, oBusy, oDone, oCnt, oMult);
    end
    for (int k = 0; k < C; k++) expc[k] = 0;
    n = 0; prev = '0;
    while (n < WIN && edges < 4 * WIN) begin
      a  = arand ? (C'($urandom) & aval) : aval;
      en = ($urandom_range(99) >= stall_pct);
      if (load_mid && n == 50) begin
        iLoadB = 1'b1; iB = {C{8'd10}};
      end
      iA = a; iEn = en;
      @(posedge iClk); edges++;
      @(negedge iClk);
      iLoadB = 1'b0;
      if (en) begin
        for (int k = 0; k < C; k++) begin
          gt = model_w[k] > sobol_ref(n);
          pb = bip ? ~(a[k] ^ gt) : (a[k] & gt);
          pk[k] = pb;
          expc[k] += int'(pb);
        end
        n++;
        if (n < WIN) begin
          n_chk++;
          if (oMult !== pk || oDone !== 1'b0 || oBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s step %0d: mult=%b done=%b busy=%b, want mult=%b done=0 busy=1",
                     tag, n, oMult, oDone, oBusy, pk);
          end
        end else begin
          n_chk++;
          if (oDone !== 1'b1 || oBusy !== 1'b0 || oMult !== '0) begin
            n_fail++;
            $display("FAIL %s end flags: done=%b busy=%b mult=%b, want 1 0 0", tag, oDone, oBusy, oMult);
          end
          for (int k = 0; k < C; k++) begin
            got_cnt[k] = int'(oCnt[k*CW +: CW]);
            n_chk++;
            if (got_cnt[k] != expc[k]) begin
              n_fail++;
              $display("FAIL %s count lane%0d: got %0d want %0d", tag, k, got_cnt[k], expc[k]);
            end
          end
        end
      end else begin
        stalls++;
        n_chk++;
        if (oMult !== prev || oDone !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stall hold: mult=%b done=%b, want mult=%b done=0", tag, oMult, oDone, prev);
        end
      end
      prev = oMult;
    end
    got_edges = edges; got_stalls = stalls;
    if (n < WIN) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: %0d enabled cycles after %0d edges, want %0d", tag, n, edges, WIN);
    end
    iEn = 1'b0;
    if (post_idle) begin
      @(negedge iClk);
      n_chk++;
      if (oDone !== 1'b0 || oBusy !== 1'b0 || oMult !== '0) begin
        n_fail++;
        $display("FAIL %s after done: done=%b busy=%b mult=%b, want 0 0 0", tag, oDone, oBusy, oMult);
      end
      for (int k = 0; k < C; k++) begin
        n_chk++;
        if (int'(oCnt[k*CW +: CW]) != expc[k]) begin
          n_fail++;
          $display("FAIL %s hold lane%0d: got %0d want %0d", tag, k, oCnt[k*CW +: CW], expc[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iA = '0; iB = '0; iLoadB = 1'b0; iStart = 1'b0; iEn = 1'b0;
`ifdef REP_UMUL_BIPOLAR_EN
    iBipolar = 1'b0;
`endif
    for (int k = 0; k < C; k++) model_w[k] = 0;
    #12;
    n_chk++;
    if (oMult !== '0 || oCnt !== '0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: mult=%b cnt=%h busy=%b done=%b, want all 0", oMult, oCnt, oBusy, oDone);
    end
    @(negedge iClk); iRstN = 1'b1;
    @(negedge iClk);
  endtask

  task automatic test_unipolar_mid();
    logic [C*BW-1:0] b;
    b = $urandom; b[7:0] = 8'd128;
    run_window(b, 1'b1, '1, 1'b0, 0, 1'b0, 1'b0, 1'b1, "mid");
    n_chk++;
    if (got_cnt[0] != 128 || got_edges != WIN + 1) begin
      n_fail++;
      $display("FAIL mid result: lane0=%0d edges=%0d, want 128 and %0d", got_cnt[0], got_edges, WIN + 1);
    end
  endtask

  task automatic test_extremes();
    logic [C*BW-1:0] b;
    b = {8'd200, 8'd255, 8'd1, 8'd0};
    run_window(b, 1'b1, '1, 1'b0, 0, 1'b0, 1'b0, 1'b1, "ext");
    n_chk++;
    if (got_cnt[0] != 0 || got_cnt[1] != 1 || got_cnt[2] != 255 || got_cnt[3] != 200) begin
      n_fail++;
      $display("FAIL ext counts: got %0d %0d %0d %0d want 0 1 255 200",
               got_cnt[0], got_cnt[1], got_cnt[2], got_cnt[3]);
    end
    run_window(b, 1'b0, 4'b0111, 1'b0, 0, 1'b0, 1'b0, 1'b1, "ext_a0");
    n_chk++;
    if (got_cnt[3] != 0 || got_cnt[2] != 255) begin
      n_fail++;
      $display("FAIL ext_a0 counts: lane3=%0d lane2=%0d want 0 255", got_cnt[3], got_cnt[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++) run_window($urandom, 1'b1, '1, 1'b1, 0, 1'b0, 1'b0, 1'b1, "rand");
  endtask

  task automatic test_stalls();
    logic [C*BW-1:0] b;
    b = $urandom; b[7:0] = 8'd128;
    run_window(b, 1'b1, '1, 1'b0, 50, 1'b0, 1'b0, 1'b1, "stall");
    n_chk++;
    if (got_cnt[0] != 128 || got_stalls == 0 || got_edges != WIN + 1 + got_stalls) begin
      n_fail++;
      $display("FAIL stall result: lane0=%0d edges=%0d stalls=%0d, want 128 and %0d edges",
               got_cnt[0], got_edges, got_stalls, WIN + 1 + got_stalls);
    end
  endtask

  task automatic test_load_start();
    run_window({C{8'd77}}, 1'b1, '1, 1'b0, 0, 1'b0, 1'b1, 1'b1, "ld_run");
    n_chk++;
    if (got_cnt[0] != 77 || got_cnt[3] != 77) begin
      n_fail++;
      $display("FAIL ld_run: lane0=%0d lane3=%0d want 77 77", got_cnt[0], got_cnt[3]);
    end
    run_window({C{8'd10}}, 1'b1, '1, 1'b0, 0, 1'b0, 1'b0, 1'b1, "ld_start");
    n_chk++;
    if (got_cnt[0] != 10 || got_cnt[2] != 10) begin
      n_fail++;
      $display("FAIL ld_start: lane0=%0d lane2=%0d want 10 10", got_cnt[0], got_cnt[2]);
    end
  endtask

  task automatic test_back_to_back();
    run_window($urandom, 1'b1, '1, 1'b1, 10, 1'b0, 1'b0, 1'b0, "b2b_a");
    run_window($urandom, 1'b1, '1, 1'b1, 10, 1'b0, 1'b0, 1'b1, "b2b_b");
  endtask

  task automatic test_reset_mid();
    bit seen;
    iB = {C{8'd99}}; iLoadB = 1'b1; iStart = 1'b1; iA = '1; iEn = 1'b1;
    @(negedge iClk);
    iLoadB = 1'b0; iStart = 1'b0;
    repeat (100) @(negedge iClk);
    iRstN = 1'b0;
    #1;
    n_chk++;
    if (oMult !== '0 || oCnt !== '0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: mult=%b cnt=%h busy=%b done=%b, want all 0", oMult, oCnt, oBusy, oDone);
    end
    for (int k = 0; k < C; k++) model_w[k] = 0;
    @(negedge iClk); iRstN = 1'b1;
    seen = 1'b0;
    repeat (WIN + 20) begin
      @(negedge iClk);
      if (oDone || oBusy) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_mid idle: saw busy/done=1 after reset, want 0");
    end
    iEn = 1'b0;
    run_window($urandom, 1'b1, '1, 1'b1, 0, 1'b0, 1'b0, 1'b1, "rst_next");
  endtask

`ifdef REP_UMUL_BIPOLAR_EN
  task automatic test_bipolar();
    run_window({C{8'd64}}, 1'b1, '1, 1'b0, 0, 1'b1, 1'b0, 1'b1, "bip_a1");
    n_chk++;
    if (got_cnt[0] != 64) begin
      n_fail++;
      $display("FAIL bip_a1: lane0=%0d want 64", got_cnt[0]);
    end
    run_window({C{8'd64}}, 1'b1, '0, 1'b0, 0, 1'b1, 1'b0, 1'b1, "bip_a0");
    n_chk++;
    if (got_cnt[0] != 192) begin
      n_fail++;
      $display("FAIL bip_a0: lane0=%0d want 192", got_cnt[0]);
    end
    run_window($urandom, 1'b1, '1, 1'b1, 20, 1'b0, 1'b0, 1'b1, "uni_after_bip");
  endtask
`endif

  initial begin
    test_reset();
    test_unipolar_mid();
    test_extremes();
    test_random();
    test_stalls();
    test_load_start();
    test_back_to_back();
    test_reset_mid();
`ifdef REP_UMUL_BIPOLAR_EN
    test_bipolar();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
